// File: rtl/status_array.sv
// Instruction cache status array: single-port row storage with per-field masked
// writes and a per-row written flag so reads of never-written rows are flagged.
module status_array #(
  parameter int ADDR_WIDTH = 6,
  parameter int NUM_BLOCKS = 4,
  parameter int ROW_WIDTH  = 8
) (
  input  logic                  gated_clk,
  input  logic                  arst_n,
  input  logic                  i_halt,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [ROW_WIDTH-1:0]  i_data,
  input  logic                  i_wen,
  input  logic [NUM_BLOCKS-1:0] i_wmask,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [ROW_WIDTH-1:0]  o_rdata,
  output logic                  o_rvalid,
  output logic                  o_runinit,
  output logic                  o_all_written
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int FW    = ROW_WIDTH / NUM_BLOCKS;

  logic [ROW_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]     written;
  logic                 accept;
  logic                 do_write;
  logic                 do_read;

  assign o_ready  = ~i_halt;
  assign accept   = i_valid & o_ready;
  assign do_write = accept & i_wen & (|i_wmask);
  assign do_read  = accept & ~i_wen;

  // NOTE: the array has no reset; the written flags alone give rows meaning,
  // which keeps the storage a plain reset-free register file.
  always_ff @(posedge gated_clk) begin
    if (do_write) begin
      for (int k = 0; k < NUM_BLOCKS; k++) begin
        if (i_wmask[k]) mem[i_addr][k*FW +: FW] <= i_data[k*FW +: FW];
      end
    end
  end

  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      written       <= '0;
      o_all_written <= 1'b0;
    end else begin
      if (do_write) written[i_addr] <= 1'b1;
      // Samples the flags before this edge's update, so it rises one cycle
      // after the last flag is set.
      o_all_written <= &written;
    end
  end

  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      o_rdata   <= '0;
      o_runinit <= 1'b0;
      o_rvalid  <= 1'b0;
    end else begin
      o_rvalid <= do_read;
      if (do_read) begin
        o_rdata   <= mem[i_addr];
        o_runinit <= ~written[i_addr];
      end
    end
  end

endmodule

// File: tb/tb_status_array.sv
// Directed bench for status_array: requests push expected read responses into
// a queue; a negedge monitor pops and compares on every o_rvalid.
module tb_status_array;

  localparam int AW = 6;
  localparam int NB = 4;
  localparam int RW = 8;

  logic          gated_clk = 1'b0;
  logic          arst_n    = 1'b1;
  logic          i_halt    = 1'b0;
  logic [AW-1:0] i_addr    = '0;
  logic [RW-1:0] i_data    = '0;
  logic          i_wen     = 1'b0;
  logic [NB-1:0] i_wmask   = '0;
  logic          i_valid   = 1'b0;
  logic          o_ready;
  logic [RW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_runinit;
  logic          o_all_written;

  typedef struct {
    logic [RW-1:0] data;
    logic          uninit;
    bit            chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  status_array #(.ADDR_WIDTH(AW), .NUM_BLOCKS(NB), .ROW_WIDTH(RW)) dut (
    .gated_clk    (gated_clk),
    .arst_n       (arst_n),
    .i_halt       (i_halt),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .i_wen        (i_wen),
    .i_wmask      (i_wmask),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_rdata      (o_rdata),
    .o_rvalid     (o_rvalid),
    .o_runinit    (o_runinit),
    .o_all_written(o_all_written)
  );

  always #5 gated_clk = ~gated_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one request for exactly one edge, returning #1 after that edge.
  task automatic issue(input logic wen, input int addr, input logic [RW-1:0] data,
                       input logic [NB-1:0] mask);
    i_valid = 1'b1;
    i_wen   = wen;
    i_addr  = AW'(addr);
    i_data  = data;
    i_wmask = mask;
    @(posedge gated_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [RW-1:0] data, input logic [NB-1:0] mask);
    issue(1'b1, addr, data, mask);
  endtask

  task automatic rd(input int addr, input logic [RW-1:0] exp_data, input logic exp_uninit,
                    input bit chk_data);
    exp_t e;
    e.data     = exp_data;
    e.uninit   = exp_uninit;
    e.chk_data = chk_data;
    sb.push_back(e);
    issue(1'b0, addr, '0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge gated_clk);
    #1;
  endtask

  // Full sweep with all_written held low through the last write edge.
  task automatic sweep(input logic [RW-1:0] data, input string tag);
    for (int r = 0; r < (1 << AW); r++) begin
      wr(r, data, '1);
      check({tag, "_all_written_low"}, o_all_written, 1'b0);
    end
    @(posedge gated_clk);
    #1;
    check({tag, "_all_written_high"}, o_all_written, 1'b1);
  endtask

  always @(negedge gated_clk) begin
    if (o_rvalid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_rvalid: got rdata %0h with no read outstanding at %0t",
                 o_rdata, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_data) check("rdata", o_rdata, e.data);
        check("runinit", o_runinit, e.uninit);
      end
    end
  end

  initial begin
    // Reset asserted mid-cycle; outputs must clear without a clock edge.
    #2 arst_n = 1'b0;
    #1;
    check("reset_rdata", o_rdata, 8'h00);
    check("reset_rvalid", o_rvalid, 1'b0);
    check("reset_runinit", o_runinit, 1'b0);
    check("reset_all_written", o_all_written, 1'b0);
    check("reset_ready", o_ready, 1'b1);
    #19 arst_n = 1'b1;
    idle(1);

    // Unwritten row: contents undefined, only the flag is checked.
    rd(5, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Zero-mask write is a no-op and leaves the row unwritten.
    wr(7, 8'hFF, 4'b0000);
    rd(7, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Partial mask clears fields 0 and 2 only.
    wr(3, 8'hFF, 4'b1111);
    wr(3, 8'h00, 4'b0101);
    rd(3, 8'hCC, 1'b0, 1'b1);
    idle(1);

    // Write then read of the same row on the next cycle.
    wr(9, 8'hA5, 4'b1111);
    rd(9, 8'hA5, 1'b0, 1'b1);
    idle(1);

    // Back-to-back reads keep o_rvalid high.
    rd(9, 8'hA5, 1'b0, 1'b1);
    rd(3, 8'hCC, 1'b0, 1'b1);
    check("b2b_rvalid_1", o_rvalid, 1'b1);
    rd(3, 8'hCC, 1'b0, 1'b1);
    check("b2b_rvalid_2", o_rvalid, 1'b1);
    idle(2);

    // Halt: requests are refused, outputs frozen at the last read.
    i_halt  = 1'b1;
    i_valid = 1'b1;
    i_wen   = 1'b0;
    i_addr  = AW'(9);
    #1;
    check("halt_ready", o_ready, 1'b0);
    idle(3);
    check("halt_rvalid", o_rvalid, 1'b0);
    check("halt_rdata_frozen", o_rdata, 8'hCC);
    check("halt_runinit_frozen", o_runinit, 1'b0);
    i_wen   = 1'b1;
    i_addr  = AW'(3);
    i_data  = 8'h00;
    i_wmask = 4'b1111;
    idle(2);
    i_valid = 1'b0;
    i_halt  = 1'b0;
    #1;
    check("unhalt_ready", o_ready, 1'b1);
    rd(3, 8'hCC, 1'b0, 1'b1);
    idle(1);

    // Initializer sweep.
    check("pre_sweep_all_written", o_all_written, 1'b0);
    sweep(8'h00, "sweep1");
    rd(0, 8'h00, 1'b0, 1'b1);
    rd(63, 8'h00, 1'b0, 1'b1);
    rd(3, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Reset while a read response is on the outputs.
    wr(9, 8'hA5, 4'b1111);
    rd(9, 8'hA5, 1'b0, 1'b1);
    #6;
    arst_n = 1'b0;
    #1;
    check("midrst_rdata", o_rdata, 8'h00);
    check("midrst_rvalid", o_rvalid, 1'b0);
    check("midrst_runinit", o_runinit, 1'b0);
    check("midrst_all_written", o_all_written, 1'b0);
    #5 arst_n = 1'b1;
    idle(1);

    // Reset halfway through a sweep: earlier writes no longer count.
    for (int r = 0; r < 32; r++) wr(r, 8'h11, '1);
    #3 arst_n = 1'b0;
    #4 arst_n = 1'b1;
    idle(1);
    check("halfsweep_all_written", o_all_written, 1'b0);
    rd(10, 8'h00, 1'b1, 1'b0);
    idle(1);
    sweep(8'h5A, "sweep2");
    rd(10, 8'h5A, 1'b0, 1'b1);
    rd(63, 8'h5A, 1'b0, 1'b1);

    // Drain outstanding responses with a bounded wait.
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge gated_clk);
    #6;
    check("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
